// File: rtl/vga_pkg.sv
// Shared definitions for the VGA DAC/timing block: default 640x480@60 timing,
// bus widths, DAC write-phase encoding, monochrome mode codes and the palette
// entry layout.
package vga_pkg;

  // Default horizontal timing (pixels)
  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  // Default vertical timing (lines)
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FP     = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 33;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic SYNC_ACT = 1'b0;

  localparam int unsigned CNT_W     = 10;
  localparam int unsigned IDX_W     = 8;
  localparam int unsigned COMP_W    = 6;
  localparam int unsigned DIN_W     = 8;
  localparam int unsigned MODE_W    = 2;
  localparam int unsigned PAL_DEPTH = 256;

  typedef enum logic [1:0] {
    PH_R = 2'd0,
    PH_G = 2'd1,
    PH_B = 2'd2
  } dac_phase_t;

  typedef enum logic [MODE_W-1:0] {
    MODE_COLOUR = 2'b00,
    MODE_GREEN  = 2'b01,
    MODE_AMBER  = 2'b10,
    MODE_GREY   = 2'b11
  } mono_mode_t;

  // One palette entry, R in the top bits
  typedef struct packed {
    logic [COMP_W-1:0] r;
    logic [COMP_W-1:0] g;
    logic [COMP_W-1:0] b;
  } rgb_t;

endpackage

// File: rtl/vga_dac_timing_if.sv
// Bundle of the pixel-fetch, CPU DAC-write and video-output signals of
// vga_dac_timing.
//   master : driver side (pixel fetch + CPU), sees timing and video outputs
//   slave  : vga_dac_timing itself
interface vga_dac_timing_if;
  import vga_pkg::*;

  logic              pix_en;
  logic [IDX_W-1:0]  pix_index;
  logic [CNT_W-1:0]  hcount;
  logic [CNT_W-1:0]  vcount;
  logic              active;
  logic              dac_wr_idx;
  logic              dac_wr_data;
  logic [DIN_W-1:0]  dac_din;
  logic              mode_we;
  logic [MODE_W-1:0] monochrome_switcher;
  logic [COMP_W-1:0] VGA_R;
  logic [COMP_W-1:0] VGA_G;
  logic [COMP_W-1:0] VGA_B;
  logic              VGA_HSYNC;
  logic              VGA_VSYNC;

  modport master (
    output pix_en, pix_index, dac_wr_idx, dac_wr_data, dac_din, mode_we,
    input  hcount, vcount, active, monochrome_switcher,
           VGA_R, VGA_G, VGA_B, VGA_HSYNC, VGA_VSYNC
  );

  modport slave (
    input  pix_en, pix_index, dac_wr_idx, dac_wr_data, dac_din, mode_we,
    output hcount, vcount, active, monochrome_switcher,
           VGA_R, VGA_G, VGA_B, VGA_HSYNC, VGA_VSYNC
  );

endinterface

// File: rtl/vga_palette_ram.sv
// 256 x 18-bit colour palette: one write port, one synchronous read-first
// read port. No reset, so it maps onto a block RAM.
//   clk     : clock
//   we      : write enable, wr_addr/wr_data : write port
//   re      : read enable,  rd_addr/rd_data : registered read port
module vga_palette_ram
  import vga_pkg::*;
(
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_addr,
  input  rgb_t             wr_data,
  input  logic             re,
  input  logic [IDX_W-1:0] rd_addr,
  output rgb_t             rd_data
);

  rgb_t mem [PAL_DEPTH];

  // Non-blocking write and read in one block: a same-cycle read of the
  // entry being written returns the old contents.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    if (re) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/vga_dac_timing.sv
// VGA pixel source: 640x480@60 raster counters and syncs, a two-stage pixel
// pipeline through the colour palette, the CPU-side DAC write sequencer
// (index, then R, G, B with auto-increment) and the monochrome mode register.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : vga_dac_timing_if.slave (pixel fetch, CPU writes, video out)
module vga_dac_timing #(
  parameter int unsigned H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int unsigned H_FP     = vga_pkg::H_FP,
  parameter int unsigned H_SYNC   = vga_pkg::H_SYNC,
  parameter int unsigned H_BP     = vga_pkg::H_BP,
  parameter int unsigned V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int unsigned V_FP     = vga_pkg::V_FP,
  parameter int unsigned V_SYNC   = vga_pkg::V_SYNC,
  parameter int unsigned V_BP     = vga_pkg::V_BP,
  parameter logic        SYNC_ACT = vga_pkg::SYNC_ACT
) (
  input  logic             clk,
  input  logic             rst_n,
  vga_dac_timing_if.slave  bus
);
  import vga_pkg::*;

  localparam int unsigned H_LEN = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_LEN = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_LEN - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_LEN - 1);
  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  // ---------------- raster counters ----------------
  logic [CNT_W-1:0] hcount_q;
  logic [CNT_W-1:0] vcount_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcount_q <= '0;
      vcount_q <= '0;
    end else if (bus.pix_en) begin
      if (hcount_q == H_LAST) begin
        hcount_q <= '0;
        vcount_q <= (vcount_q == V_LAST) ? '0 : vcount_q + CNT_W'(1);
      end else begin
        hcount_q <= hcount_q + CNT_W'(1);
      end
    end
  end

  // Undelayed visible-area flag and raw syncs
  logic active_c;
  logic hsync_raw_c;
  logic vsync_raw_c;

  always_comb begin
    active_c    = (hcount_q < H_VIS) && (vcount_q < V_VIS);
    hsync_raw_c = ((hcount_q >= HS_FIRST) && (hcount_q <= HS_LAST)) ? SYNC_ACT : ~SYNC_ACT;
    vsync_raw_c = ((vcount_q >= VS_FIRST) && (vcount_q <= VS_LAST)) ? SYNC_ACT : ~SYNC_ACT;
  end

  // ---------------- pixel pipeline ----------------
  logic [IDX_W-1:0] idx_s1;
  logic             act_s1, hs_s1, vs_s1;
  logic             act_s2, hs_s2, vs_s2;
  rgb_t             pal_rd;

  // Stage 1 captures the fetch; stage 2 flags travel alongside the palette read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_s1 <= '0;
      act_s1 <= 1'b0;
      hs_s1  <= ~SYNC_ACT;
      vs_s1  <= ~SYNC_ACT;
      act_s2 <= 1'b0;
      hs_s2  <= ~SYNC_ACT;
      vs_s2  <= ~SYNC_ACT;
    end else if (bus.pix_en) begin
      idx_s1 <= bus.pix_index;
      act_s1 <= active_c;
      hs_s1  <= hsync_raw_c;
      vs_s1  <= vsync_raw_c;
      act_s2 <= act_s1;
      hs_s2  <= hs_s1;
      vs_s2  <= vs_s1;
    end
  end

  // ---------------- DAC write sequencer ----------------
  dac_phase_t        phase_q, phase_d;
  logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
  logic [COMP_W-1:0] r_q, r_d;
  logic [COMP_W-1:0] g_q, g_d;
  logic              pal_we_c;
  rgb_t              pal_wdata_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q  <= PH_R;
      wr_idx_q <= '0;
      r_q      <= '0;
      g_q      <= '0;
    end else begin
      phase_q  <= phase_d;
      wr_idx_q <= wr_idx_d;
      r_q      <= r_d;
      g_q      <= g_d;
    end
  end

  // Index load has priority; a data strobe in the same cycle is dropped
  always_comb begin
    phase_d     = phase_q;
    wr_idx_d    = wr_idx_q;
    r_d         = r_q;
    g_d         = g_q;
    pal_we_c    = 1'b0;
    pal_wdata_c = '{r: r_q, g: g_q, b: bus.dac_din[COMP_W-1:0]};
    if (bus.dac_wr_idx) begin
      wr_idx_d = bus.dac_din;
      phase_d  = PH_R;
      r_d      = '0;
      g_d      = '0;
    end else if (bus.dac_wr_data) begin
      case (phase_q)
        PH_R: begin
          r_d     = bus.dac_din[COMP_W-1:0];
          phase_d = PH_G;
        end
        PH_G: begin
          g_d     = bus.dac_din[COMP_W-1:0];
          phase_d = PH_B;
        end
        PH_B: begin
          pal_we_c = 1'b1;
          wr_idx_d = wr_idx_q + IDX_W'(1);
          phase_d  = PH_R;
        end
        default: phase_d = PH_R;
      endcase
    end
  end

  vga_palette_ram u_palette (
    .clk     (clk),
    .we      (pal_we_c),
    .wr_addr (wr_idx_q),
    .wr_data (pal_wdata_c),
    .re      (bus.pix_en),
    .rd_addr (idx_s1),
    .rd_data (pal_rd)
  );

  // ---------------- monochrome mode register ----------------
  logic [MODE_W-1:0] mode_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mode_q <= MODE_COLOUR;
    else if (bus.mode_we) mode_q <= bus.dac_din[MODE_W-1:0];
  end

  // ---------------- outputs ----------------
  // RGB is blanked from the flag that travelled with the palette read
  assign bus.hcount              = hcount_q;
  assign bus.vcount              = vcount_q;
  assign bus.active              = active_c;
  assign bus.monochrome_switcher = mode_q;
  assign bus.VGA_R               = act_s2 ? pal_rd.r : '0;
  assign bus.VGA_G               = act_s2 ? pal_rd.g : '0;
  assign bus.VGA_B               = act_s2 ? pal_rd.b : '0;
  assign bus.VGA_HSYNC           = hs_s2;
  assign bus.VGA_VSYNC           = vs_s2;

endmodule
